// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_pkg
// Purpose  : Shared constants and helpers for the N-channel registered
//            multiplexer / arbiter (mux_arb_n) and its round-robin picker.
// Contents : MODE_FIXED / MODE_RR mode encodings, idx_w() index-width helper.
// Revision : 1.0  initial release
// ============================================================================
package mux_arb_pkg;

  // Channel-choice mode, driven on the 1-bit mode input.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of a channel index. Never smaller than one bit so that a
  // two-channel (or degenerate) configuration still has a usable port.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_arb_n_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_n_rr_pick
// Purpose  : Combinational round-robin picker. Rotates the request vector so
//            that the pointer channel sits at position 0, then selects the
//            lowest set position, and maps it back to a channel index.
// Ports    : valid     in  NCH   per-channel request
//            ptr       in  SELW  highest-priority channel (always < NCH)
//            gnt_valid out 1     at least one request present
//            gnt       out SELW  granted channel index
// Revision : 1.0  initial release
// ============================================================================
module mux_arb_n_rr_pick #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  valid,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt
);

  logic [NCH-1:0] rot;

  // (base + off) mod NCH, for base < NCH and off < NCH.
  function automatic int wrap_add(input logic [SELW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) s = s - NCH;
    return s;
  endfunction

  // rot[k] is the request of the channel k places after ptr.
  always_comb begin
    rot = '0;
    for (int k = 0; k < NCH; k++) begin
      rot[k] = valid[wrap_add(ptr, k)];
    end
  end

  // Priority encode, lowest rotated position wins; scanning downward lets
  // the last hit (the lowest) stick.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_valid = 1'b1;
        gnt       = SELW'(wrap_add(ptr, k));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_arb_n.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_n
// Purpose  : N-channel, W-bit registered multiplexer with valid/ready on each
//            input and a one-entry registered output stage with backpressure.
//            Channel choice is fixed (sel) or round-robin among valid inputs.
// Ports    : clk        in  1      clock, all state on rising edge
//            rst_n      in  1      asynchronous active-low reset
//            mode       in  1      MODE_FIXED (0) / MODE_RR (1)
//            sel        in  SELW   channel used in MODE_FIXED
//            in_valid   in  NCH    per-channel valid
//            in_data    in  NCH*W  channel i at [i*W +: W]
//            in_ready   out NCH    per-channel accept (combinational)
//            out_valid  out 1      output register holds a word
//            out_data   out W      registered word
//            out_ch     out SELW   channel that supplied out_data
//            out_ready  in  1      consumer accept
// Revision : 1.0  initial release
// ============================================================================
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter  int NCH  = 4,
  parameter  int W    = 8,
  localparam int SELW = idx_w(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*W-1:0]  in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready
);

  localparam int NEXT = 1 << SELW;   // sel can address this many channels

  logic              load;
  logic [SELW-1:0]   ptr;
  logic              rr_valid;
  logic [SELW-1:0]   rr_gnt;
  logic [NEXT-1:0]   valid_ext;
  logic              fix_valid;
  logic              gnt_valid;
  logic [SELW-1:0]   gnt;
  logic [W-1:0]      gnt_data;
  logic [SELW-1:0]   ptr_next;

  // Output stage is free, or is being drained this very cycle.
  assign load = !out_valid | out_ready;

  mux_arb_n_rr_pick #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_pick (
    .valid     (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt       (rr_gnt)
  );

  // Zero-extended valid vector so an out-of-range sel (possible only when
  // NCH is not a power of two) indexes a defined 0 instead of past the end.
  always_comb begin
    valid_ext          = '0;
    valid_ext[NCH-1:0] = in_valid;
  end

  assign fix_valid = (int'(sel) < NCH) && valid_ext[sel];

  assign gnt_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
  assign gnt       = (mode == MODE_RR) ? rr_gnt   : sel;

  // gnt is always < NCH whenever gnt_valid is set; otherwise the word is unused.
  assign gnt_data = in_data[(int'(gnt) % NCH) * W +: W];

  assign ptr_next = (gnt == SELW'(NCH - 1)) ? '0 : gnt + SELW'(1);

  // in_ready is forced low while reset is asserted even though the cleared
  // output stage would otherwise report load.
  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ready
      assign in_ready[i] = rst_n & load & gnt_valid & (gnt == SELW'(i));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (gnt_valid) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt;
        if (mode == MODE_RR) ptr <= ptr_next;
      end else begin
        // Drained with nothing to replace it; data and channel keep last value.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
